// File: rtl/button_press_classifier_pkg.sv
// Shared definitions for the push-button classifier family.
// Holds the classifier FSM state encoding, the default 12 MHz board timing
// constants (so every button instance agrees) and a counter-width helper.
`timescale 1ns/1ps
package button_press_classifier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_e;

    // 12 MHz board: 20 ms debounce, 1 s long press, 200 ms auto-repeat.
    localparam int unsigned DEF_DEBOUNCE_CYC = 240_000;
    localparam int unsigned DEF_LONG_CYC     = 12_000_000;
    localparam int unsigned DEF_REPEAT_CYC   = 2_400_000;

    // Width of a counter that must hold 0 .. n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_sync_debounce.sv
// 2-FF synchroniser followed by a debounce counter.
// Ports:
//   i_Clock       system clock, rising edge
//   i_Reset       asynchronous active-high reset
//   i_Button      raw button level, asynchronous to i_Clock
//   o_Level       debounced level (registered)
//   o_Level_Next  value o_Level takes on the coming edge (combinational)
`timescale 1ns/1ps
module button_sync_debounce
    import button_press_classifier_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Button,
    output logic o_Level,
    output logic o_Level_Next
);

    localparam int unsigned          DC_W    = cnt_width(DEBOUNCE_CYC);
    localparam logic [DC_W-1:0]      DC_LAST = DC_W'(DEBOUNCE_CYC - 1);

    logic            s1_q;
    logic            s2_q;
    logic            lvl_q;
    logic            lvl_d;
    logic [DC_W-1:0] dc_q;
    logic [DC_W-1:0] dc_d;

    always_comb begin
        lvl_d = lvl_q;
        dc_d  = '0;
        if (s2_q != lvl_q) begin
            if (dc_q == DC_LAST) begin
                lvl_d = ~lvl_q;
            end else begin
                dc_d = dc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            dc_q  <= '0;
        end else begin
            s1_q  <= i_Button;
            s2_q  <= s1_q;
            lvl_q <= lvl_d;
            dc_q  <= dc_d;
        end
    end

    assign o_Level      = lvl_q;
    assign o_Level_Next = lvl_d;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a raw push-button into debounced press events: short press on
// release, long press after LONG_CYC held cycles, then auto-repeat every
// REPEAT_CYC cycles while still held.
// Ports:
//   i_Clock        system clock, rising edge
//   i_Reset        asynchronous active-high reset
//   i_Button       raw button, active-high
//   o_Pressed      debounced level
//   o_Short_Press  1-cycle pulse on release of a hold shorter than LONG_CYC
//   o_Long_Press   1-cycle pulse when the hold reaches LONG_CYC
//   o_Repeat       1-cycle pulse every REPEAT_CYC cycles after long press
//   o_Long_Active  high from the long-press cycle until release
`timescale 1ns/1ps
module button_press_classifier
    import button_press_classifier_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Button,
    output logic o_Pressed,
    output logic o_Short_Press,
    output logic o_Long_Press,
    output logic o_Repeat,
    output logic o_Long_Active
);

    localparam int unsigned     HC_W    = cnt_width(LONG_CYC);
    localparam int unsigned     RC_W    = cnt_width(REPEAT_CYC);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(LONG_CYC - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REPEAT_CYC - 1);

    logic lvl;
    logic lvl_next;

    button_sync_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_sync_debounce (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Button    (i_Button),
        .o_Level     (lvl),
        .o_Level_Next(lvl_next)
    );

    state_e          state_q, state_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            rep_q, rep_d;
    logic            active_q, active_d;

    // The FSM follows the debounced level's next value rather than the
    // registered one, so the registered pulses line up with the o_Pressed
    // edge itself (short press in the first low cycle, long press exactly
    // LONG_CYC cycles after the rise). Release is tested before the hold
    // and repeat terminal counts, so it wins any same-cycle collision.
    always_comb begin
        state_d  = state_q;
        hc_d     = hc_q;
        rc_d     = rc_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;
        active_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lvl_next && !lvl) begin
                    state_d = ST_HELD;
                    hc_d    = '0;
                end
            end
            ST_HELD: begin
                if (!lvl_next) begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end else if (hc_q == HC_LAST) begin
                    state_d  = ST_LONG;
                    long_d   = 1'b1;
                    active_d = 1'b1;
                    rc_d     = '0;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (!lvl_next) begin
                    state_d = ST_IDLE;
                end else begin
                    active_d = 1'b1;
                    if (rc_q == RC_LAST) begin
                        rep_d = 1'b1;
                        rc_d  = '0;
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            hc_q     <= '0;
            rc_q     <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hc_q     <= hc_d;
            rc_q     <= rc_d;
            short_q  <= short_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
            active_q <= active_d;
        end
    end

    assign o_Pressed     = lvl;
    assign o_Short_Press = short_q;
    assign o_Long_Press  = long_q;
    assign o_Repeat      = rep_q;
    assign o_Long_Active = active_q;

endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Classifies a raw push-button into debounced press events for the clock's setting path: short press, long press, and auto-repeat while held. It sits between the board button pin and the control/counter logic. Its pulses drive the increment enable in place of a bare release strobe, so holding Up scrolls minutes or hours quickly. Fully synchronous to the system clock, with one event pulse per qualifying condition.

## Interface
- DEBOUNCE_CYC, 240000: consecutive stable cycles required to accept a level change (20 ms at 12 MHz); must be ≥ 1.
- LONG_CYC, 12000000: held cycles from debounced press to long-press event (1 s); must be > 1.
- REPEAT_CYC, 2400000: cycles between auto-repeat pulses after long press (200 ms); must be ≥ 2.
- i_Clock  input  1  system clock; all logic on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Button  input  1  raw button, active-high (1 = pressed), asynchronous to i_Clock.
- o_Pressed  output  1  debounced button level.
- o_Short_Press  output  1  one-cycle pulse on release after a hold shorter than LONG_CYC.
- o_Long_Press  output  1  one-cycle pulse when the hold reaches LONG_CYC.
- o_Repeat  output  1  one-cycle pulse every REPEAT_CYC cycles while still held after o_Long_Press.
- o_Long_Active  output  1  level; high from the o_Long_Press cycle until release.

## Operation
- Synchroniser: 2-FF chain on i_Button, giving the synchronised level `s`. Reset value 0.
- Debounce: register `d` (drives o_Pressed) and counter `dc`.
  - While s == d: dc = 0.
  - While s != d: dc increments.
  - When dc reaches DEBOUNCE_CYC-1 with s != d still true, d toggles on that edge and dc clears.
  - Any bounce back to s == d clears dc.
- FSM states: IDLE, HELD, LONG. Hold counter `hc`, repeat counter `rc`; widths are $clog2 of their parameter.
- IDLE:
  - d rising → HELD, hc = 0.
- HELD:
  - hc increments each cycle.
  - d low → IDLE, assert o_Short_Press.
  - Otherwise, when hc == LONG_CYC-1 → LONG, assert o_Long_Press, rc = 0.
- LONG:
  - rc increments each cycle.
  - When rc == REPEAT_CYC-1: assert o_Repeat and clear rc.
  - d low → IDLE, with no pulse.
- Boundary cases:
  - Release and long threshold in the same cycle: release wins; o_Short_Press only.
  - Release and repeat terminal count in the same cycle: release wins; no o_Repeat.
  - At most one of the three pulse outputs is high in any cycle.
- Reset (any time, including mid-hold):
  - All outputs, sync flops, d, dc, hc and rc go to 0; FSM goes to IDLE.
  - No pulse is emitted on reset entry or exit.
  - A button held through reset deassertion is treated as a fresh press after debounce.
- Counters saturate or clear as above; none wraps unobserved.

## Timing
- All outputs are registered; all reset values are 0.
- Press latency: raw i_Button high and stable from edge N gives o_Pressed high at edge N+2+DEBOUNCE_CYC (2 sync + debounce).
- Release latency: identical, N+2+DEBOUNCE_CYC.
- o_Short_Press is high in exactly the first cycle o_Pressed reads 0.
- o_Long_Press is high in the cycle exactly LONG_CYC cycles after o_Pressed first reads 1.
- o_Long_Active rises in the same cycle as o_Long_Press. It falls in the same cycle o_Pressed falls.
- Repeat schedule: first o_Repeat REPEAT_CYC cycles after o_Long_Press, then every REPEAT_CYC cycles.
- Any bounce shorter than DEBOUNCE_CYC cycles (after sync) produces no output change.

## Structure
- Shared package/include file holds:
  - FSM state encodings: IDLE = 2'd0, HELD = 2'd1, LONG = 2'd2.
  - Default timing constants for a 12 MHz board, so that every button instance agrees.
- Natural sub-module: button_sync_debounce (2-FF synchroniser + debounce counter, output `d`). It is reusable for the Set button.
- The top level (FSM, hold/repeat counters, pulse registers) stays in button_press_classifier.

## Test plan
All scenarios use DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5.

- **Clean short press:** i_Button high for 10 cycles, then low → o_Pressed high at cycle 6. Then o_Pressed low 6 cycles after the fall, with a single o_Short_Press on that cycle. No o_Long_Press.
- **Bounce rejection:** 1-0-1-0 toggles with 3-cycle pulses → o_Pressed stays 0; all pulses 0.
- **Long press with repeats:** hold for 45 cycles past o_Pressed rise →
  - o_Long_Press at +20 and o_Long_Active high from +20.
  - o_Repeat at +25, +30, +35, +40, +45.
  - No o_Short_Press on release.
- **Release coinciding with long threshold:** arrange for o_Pressed to fall in exactly the cycle hc == 19 → o_Short_Press only; o_Long_Press never asserted.
- **Reset mid-hold:** assert i_Reset during LONG →
  - All outputs go to 0 immediately (asynchronously).
  - After deassertion with the button still held: o_Pressed re-rises 6 cycles later, and o_Long_Press occurs 20 cycles after that.
- **Exclusivity check:** over 1000 cycles of random press lengths, at most one pulse output is high per cycle. Pulse counts match a reference model.
